// File: rtl/note_recorder_pkg.sv
// Shared note recorder types: sample/entry layout, FSM states, and the
// key-to-note priority decode also used by the free-mode key path.
package note_recorder_pkg;

    localparam int NOTE_W   = 4;
    localparam int OCT_W    = 2;
    localparam int SAMPLE_W = NOTE_W + OCT_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    // Entry is {note, octave, dur}; dur sits in the low bits.
    localparam int ENTRY_DUR_LSB = 0;

    function automatic int entry_oct_lsb(input int dur_w);
        return dur_w;
    endfunction

    function automatic int entry_note_lsb(input int dur_w);
        return dur_w + OCT_W;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        FLUSH,
        DONE
    } rec_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [OCT_W-1:0]  oct;
    } sample_t;

    // Lowest pressed key wins; no key gives a rest.
    function automatic logic [NOTE_W-1:0] key_to_note(input logic [6:0] keys);
        logic [NOTE_W-1:0] n;
        priority case (1'b1)
            keys[0]: n = NOTE_W'(1);
            keys[1]: n = NOTE_W'(2);
            keys[2]: n = NOTE_W'(3);
            keys[3]: n = NOTE_W'(4);
            keys[4]: n = NOTE_W'(5);
            keys[5]: n = NOTE_W'(6);
            keys[6]: n = NOTE_W'(7);
            default: n = NOTE_REST;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/note_rec_mem.sv
// Simple dual-port event RAM with a registered read port.
// A read of the address being written returns the old contents.
module note_rec_mem
    import note_recorder_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Free-play recorder: turns key activity into {note, octave, dur} events.
// Define NOTE_RECORDER_DEBOUNCE_EN to accept only samples stable over two ticks.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int DUR_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rec_en,
    input  logic                      clear,
    input  logic [6:0]                key_in,
    input  logic [OCT_W-1:0]          octave_keys,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [SAMPLE_W+DUR_W-1:0] rd_data,
    output logic [ADDR_W:0]           count,
    output logic                      recording,
    output logic                      full
);

    localparam int ENTRY_W  = SAMPLE_W + DUR_W;
    localparam int OCT_LSB  = entry_oct_lsb(DUR_W);
    localparam int NOTE_LSB = entry_note_lsb(DUR_W);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(DEPTH - 1);

    logic [6:0]        key_s1, key_s2;
    logic [OCT_W-1:0]  oct_s1, oct_s2;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_p;

    sample_t           raw, samp, cur, cur_n;
    logic [DUR_W-1:0]  dur, dur_n;
    rec_state_t        state, state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_req, wr_en;
    logic [ENTRY_W-1:0] wr_entry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1   <= '0;
            key_s2   <= '0;
            oct_s1   <= '0;
            oct_s2   <= '0;
            tick_cnt <= '0;
        end else begin
            key_s1   <= key_in;
            key_s2   <= key_s1;
            oct_s1   <= octave_keys;
            oct_s2   <= oct_s1;
            tick_cnt <= tick_p ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    assign tick_p = (tick_cnt == TICK_LAST);

    always_comb begin
        raw.note = key_to_note(key_s2);
        raw.oct  = (raw.note == NOTE_REST) ? '0 : oct_s2;
    end

`ifdef NOTE_RECORDER_DEBOUNCE_EN
    sample_t prev_tick, stable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_tick <= '0;
            stable    <= '0;
        end else if (tick_p) begin
            prev_tick <= raw;
            if (raw == prev_tick) begin
                stable <= raw;
            end
        end
    end

    assign samp = stable;
`else
    assign samp = raw;
`endif

    always_comb begin
        state_n = state;
        cur_n   = cur;
        dur_n   = dur;
        wr_req  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rec_en) state_n = ARMED;
            end
            ARMED: begin
                if (!rec_en) begin
                    state_n = IDLE;
                end else if (samp.note != NOTE_REST) begin
                    cur_n   = samp;
                    dur_n   = DUR_ONE;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!rec_en) begin
                    state_n = FLUSH;
                end else if (samp != cur) begin
                    wr_req = 1'b1;
                    cur_n  = samp;
                    dur_n  = DUR_ONE;
                end else if (tick_p) begin
                    // A saturated note is split; the tail keeps counting.
                    if (dur == DUR_MAX) begin
                        wr_req = 1'b1;
                        dur_n  = DUR_ONE;
                    end else begin
                        dur_n = dur + DUR_ONE;
                    end
                end
            end
            FLUSH: begin
                state_n = IDLE;
                wr_req  = (cur.note != NOTE_REST);
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        wr_en = wr_req && !full && !clear;
        if (wr_en && count == CNT_LAST) state_n = DONE;
        if (clear) state_n = IDLE;
    end

    always_comb begin
        wr_entry = '0;
        wr_entry[ENTRY_DUR_LSB +: DUR_W] = dur;
        wr_entry[OCT_LSB +: OCT_W]       = cur.oct;
        wr_entry[NOTE_LSB +: NOTE_W]     = cur.note;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cur    <= '0;
            dur    <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            dur   <= dur_n;
            if (clear) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                count  <= count + (ADDR_W + 1)'(1);
            end
        end
    end

    assign full      = (count == CNT_FULL);
    assign recording = (state == ARMED) || (state == CAPTURE);

    note_rec_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_note_recorder.sv
// Randomized scoreboard bench for note_recorder (default build, TICK_DIV=4).
// Expected events come from a run/duration model of the key stimulus.
module tb_note_recorder;

    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 64;
    localparam int ADDR_W   = 6;
    localparam int DUR_W    = 8;
    localparam int EW       = 6 + DUR_W;
    localparam int DMAX     = (1 << DUR_W) - 1;

    typedef struct {
        logic [6:0]  keys;
        logic [1:0]  oct;
        int unsigned len;
    } seg_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rec_en = 1'b0;
    logic              clear = 1'b0;
    logic [6:0]        key_in = '0;
    logic [1:0]        octave_keys = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [EW-1:0]     rd_data;
    logic [ADDR_W:0]   count;
    logic              recording;
    logic              full;

    int vectors = 0;
    int miscompares = 0;
    int unsigned cyc = 0;
    logic [EW-1:0] sb[$];
    int next_idx = 0;
    int rd_idx = 0;
    bit pend = 1'b0;
    int exp_cnt = 0;

    note_recorder #(
        .TICK_DIV (TICK_DIV),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DUR_W    (DUR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rec_en      (rec_en),
        .clear       (clear),
        .key_in      (key_in),
        .octave_keys (octave_keys),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .count       (count),
        .recording   (recording),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Edge count since reset release: tick edges are multiples of TICK_DIV.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic seg_t seg(input logic [6:0] k, input logic [1:0] o,
                                 input int unsigned l);
        seg_t s;
        s.keys = k;
        s.oct  = o;
        s.len  = l;
        return s;
    endfunction

    function automatic logic [5:0] norm(input logic [6:0] k, input logic [1:0] o);
        int n = 0;
        for (int i = 6; i >= 0; i--) if (k[i]) n = i + 1;
        return (n == 0) ? 6'd0 : {4'(n), o};
    endfunction

    // Keys driven after edge d reach the recorder's decision at edge d+3.
    // Equal-sample segments merge into runs; a run spanning edges (S,T)
    // lasts 1 + (tick edges strictly inside) ticks, split every DMAX.
    function automatic int model(input seg_t segs[$], input int unsigned d0,
                                 input bit flush, input int base);
        logic [5:0] rs[$];
        int unsigned rb[$];
        int unsigned re[$];
        int unsigned t = d0;
        int unsigned n;
        int out = base;
        logic [5:0] s;
        foreach (segs[i]) begin
            s = norm(segs[i].keys, segs[i].oct);
            if (rs.size() > 0 && rs[rs.size()-1] == s) begin
                re[re.size()-1] = t + segs[i].len + 3;
            end else begin
                rs.push_back(s);
                rb.push_back(t + 3);
                re.push_back(t + segs[i].len + 3);
            end
            t += segs[i].len;
        end
        while (rs.size() > 0 && rs[0] == 6'd0) begin
            void'(rs.pop_front());
            void'(rb.pop_front());
            void'(re.pop_front());
        end
        if (rs.size() > 0) begin
            s = rs[rs.size()-1];
            if (!flush || s == 6'd0) begin
                void'(rs.pop_back());
                void'(rb.pop_back());
                void'(re.pop_back());
            end
        end
        foreach (rs[i]) begin
            n = (re[i] - 1) / TICK_DIV - rb[i] / TICK_DIV;
            while (n >= DMAX) begin
                if (out < DEPTH) begin
                    sb.push_back({rs[i], DUR_W'(DMAX)});
                    out++;
                end
                n -= DMAX;
            end
            if (out < DEPTH) begin
                sb.push_back({rs[i], DUR_W'(n + 1)});
                out++;
            end
        end
        return out;
    endfunction

    task automatic run_session(input seg_t segs[$], input bit flush);
        int unsigned d0;
        step();
        d0 = cyc;
        exp_cnt = model(segs, d0, flush, exp_cnt);
        rec_en = 1'b1;
        foreach (segs[i]) begin
            key_in = segs[i].keys;
            octave_keys = segs[i].oct;
            repeat (segs[i].len) step();
        end
        if (flush) begin
            step();
            step();
            rec_en = 1'b0;
            repeat (2) step();
            key_in = '0;
            octave_keys = '0;
            repeat (4) step();
        end
    endtask

    task automatic align();
        do step(); while (cyc % TICK_DIV != 0);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || pend) && k < 400) begin
            step();
            k++;
        end
        check({name, "_pending"}, sb.size(), 0);
        sb.delete();
        check({name, "_count"}, int'(count), exp_cnt);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_cnt = 0;
        check("clear_count", int'(count), 0);
        check("clear_full", int'(full), 0);
    endtask

    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                next_idx = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL entry[%0d]: got %h, expected no write",
                                 rd_idx, rd_data);
                    end else begin
                        e = sb.pop_front();
                        if (rd_data !== e) begin
                            miscompares++;
                            $display("FAIL entry[%0d]: got %h, expected %h",
                                     rd_idx, rd_data, e);
                        end
                    end
                    pend = 1'b0;
                end
                if (int'(count) < next_idx) next_idx = int'(count);
                if (int'(count) > next_idx) begin
                    rd_addr = ADDR_W'(next_idx);
                    rd_idx = next_idx;
                    next_idx++;
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : stim
        seg_t s[$];
        int n;

        #1 reset = 1'b0;
        #1;
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_recording", int'(recording), 0);
        check("rst_rd_data", int'(rd_data), 0);
        #1 reset = 1'b1;

        // Basic capture: 12 ticks of note 1 then 5 ticks of note 3.
        align();
        s.delete();
        s.push_back(seg(7'b0000001, 2'd1, 12 * TICK_DIV));
        s.push_back(seg(7'b0000100, 2'd1, 5 * TICK_DIV));
        run_session(s, 1'b1);
        drain("basic");
        check("basic_two", int'(count), 2);
        check("basic_recording", int'(recording), 0);
        do_clear();

        // Leading and trailing rests are dropped.
        align();
        s.delete();
        s.push_back(seg(7'b0000000, 2'd3, 3 * TICK_DIV));
        s.push_back(seg(7'b0000010, 2'd2, 4 * TICK_DIV));
        s.push_back(seg(7'b0000000, 2'd1, 2 * TICK_DIV));
        run_session(s, 1'b1);
        drain("rests");
        check("rests_one", int'(count), 1);
        do_clear();

        // Long note is split at saturation.
        align();
        s.delete();
        s.push_back(seg(7'b1000000, 2'd3, 300 * TICK_DIV));
        run_session(s, 1'b1);
        drain("sat");
        check("sat_two", int'(count), 2);
        do_clear();

        // Short glitch inside a held note is recorded undebounced.
        align();
        s.delete();
        s.push_back(seg(7'b0000001, 2'd0, 5 * TICK_DIV));
        s.push_back(seg(7'b0001000, 2'd2, 2));
        s.push_back(seg(7'b0000001, 2'd0, 5 * TICK_DIV));
        run_session(s, 1'b1);
        drain("glitch");
        check("glitch_three", int'(count), 3);
        do_clear();

        for (int r = 0; r < 6; r++) begin
            s.delete();
            n = $urandom_range(4, 12);
            for (int i = 0; i < n; i++) begin
                s.push_back(seg(($urandom_range(0, 3) == 0) ? 7'd0 :
                                7'($urandom_range(1, 127)),
                                2'($urandom_range(0, 3)),
                                $urandom_range(1, 40)));
            end
            run_session(s, 1'b1);
            drain("rand");
            do_clear();
        end

        // Fill the buffer: DONE holds until clear, even with rec_en high.
        s.delete();
        for (int i = 0; i < 70; i++) begin
            s.push_back(seg((i % 2 == 0) ? 7'b0000001 : 7'b0000010, 2'd1, TICK_DIV));
        end
        run_session(s, 1'b1);
        drain("full");
        check("full_flag", int'(full), 1);
        check("full_count", int'(count), DEPTH);
        rec_en = 1'b1;
        repeat (3) step();
        check("done_recording", int'(recording), 0);
        check("done_count", int'(count), DEPTH);
        do_clear();
        step();
        check("rearm_recording", int'(recording), 1);
        rec_en = 1'b0;
        repeat (2) step();

        // Asynchronous reset while capturing the sixth note.
        s.delete();
        for (int i = 0; i < 6; i++) begin
            s.push_back(seg(7'(1 << i), 2'd2, 8));
        end
        run_session(s, 1'b0);
        drain("midrst");
        check("midrst_recording", int'(recording), 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_full", int'(full), 0);
        check("midrst_rec0", int'(recording), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        rec_en = 1'b0;
        key_in = '0;
        #2 reset = 1'b1;
        exp_cnt = 0;
        repeat (4) step();
        check("post_rst_count", int'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Records live free-mode playing as a compact event list: note, octave and duration.
- Produces the data that the auto-play song reader consumes. This block is the writer end of the song-memory interface.
- Sits beside the key scanner in Main. It samples key_in and octave_keys and stores events in an internal buffer.
- The player fetches entries through a synchronous read port.

Parameters:
- TICK_DIV, 500000, clk cycles per duration tick (10 ms at 50 MHz).
- DEPTH, 64, number of event entries; must be a power of 2.
- ADDR_W, 6, log2(DEPTH).
- DUR_W, 8, duration field width in ticks.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- rec_en  in  1  level; high = record session active.
- clear  in  1  single-cycle pulse; empties the buffer.
- key_in  in  7  raw note keys, bit0 = note 1 .. bit6 = note 7.
- octave_keys  in  2  octave select, sampled with the note.
- rd_addr  in  ADDR_W  player read address.
- rd_data  out  6+DUR_W  {note[3:0], octave[1:0], dur[DUR_W-1:0]}; registered.
- count  out  ADDR_W+1  number of valid entries.
- recording  out  1  high in ARMED or CAPTURE.
- full  out  1  buffer holds DEPTH entries.

Behaviour:
- Reset (reset=0, async): state IDLE, count=0, wr_ptr=0, rd_data=0, recording=0, full=0, tick counter=0, synchroniser flops=0. Buffer contents are undefined.
- Input sampling: key_in and octave_keys pass through a 2-flop synchroniser.
- Note encoding: note = index of the lowest set bit + 1, giving 1..7; 0 when no key is pressed (rest). This matches the note_out encoding.
- Sample = {note, octave}. Octave is ignored (stored as 0) when note=0.
- Tick: a free-running counter, 0..TICK_DIV-1. tick_p pulses for one cycle on wrap.
- States:
  - IDLE: rec_en=1 -> ARMED.
  - ARMED: waits for a sample with note≠0. Leading rests are not stored. On a nonzero sample: cur=sample, dur=1, go to CAPTURE. rec_en=0 -> IDLE.
  - CAPTURE: dur increments on each tick_p.
    - Sample≠cur: write {cur,dur}, then cur=sample, dur=1.
    - dur reaches 2^DUR_W-1 on tick_p: write {cur,dur}, then dur=1 with cur unchanged (long note is split).
    - Change and saturation in the same cycle: one write only, via the change rule.
    - rec_en falls: go to FLUSH.
  - FLUSH: writes {cur,dur} if cur.note≠0 (trailing rests dropped), then IDLE. Takes 1 cycle.
  - DONE: entered when a write makes count=DEPTH. full=1 and no further writes occur. Stays in DONE until clear, regardless of rec_en.
- Write: buffer[wr_ptr]<=entry; wr_ptr++ and count++ in the same cycle. Writes never occur when count=DEPTH.
- Read: rd_data <= buffer[rd_addr] every cycle, 1-cycle latency, independent of the state.
  - Reads of the address being written in the same cycle return the old data.
  - Reads at addresses >= count return stale data; the player must bound its reads by count.
- clear: synchronous, highest priority over every state transition.
  - Sets count=0, wr_ptr=0, full=0, state IDLE.
  - If rec_en is still high, the next cycle re-arms (IDLE -> ARMED).
- recording = (state==ARMED || state==CAPTURE).
- Durations are measured from tick boundaries, so accuracy is ±1 tick. The minimum stored dur is 1.

Optional Feature:
- Macro: NOTE_RECORDER_DEBOUNCE_EN.
- When defined:
  - A new synchronised sample is accepted only after it has been equal on two consecutive tick_p edges.
  - Glitches shorter than 1 tick are ignored.
  - Accepted changes are delayed by 1–2 ticks; the duration of the outgoing note absorbs that delay.
- When undefined: changes are accepted on the cycle they leave the synchroniser.

Decomposition:
- Shared package/header holds:
  - NOTE_W=4, OCT_W=2, NOTE_REST=0.
  - Entry field offsets.
  - The state encodings IDLE/ARMED/CAPTURE/FLUSH/DONE.
  - A key-to-note priority function, shared with Main's free-mode decode.
- One natural sub-module: note_rec_mem, a DEPTH×(6+DUR_W) simple dual-port RAM with a registered read, which maps to block RAM.

Test Plan (TICK_DIV=4 in the bench):
- Basic capture:
  - Stimulus: rec_en=1; key_in=0000001 for 12 ticks, then 0000100 for 5 ticks, octave=1; then rec_en=0.
  - Response: count=2; entry0={1,1,12}, entry1={3,1,5}; recording returns to 0 one cycle after FLUSH.
- Leading and trailing rests:
  - Stimulus: rec_en=1, 3 ticks of key_in=0, key 2 for 4 ticks, rest for 2 ticks, rec_en=0.
  - Response: count=1 with entry {2,oct,4}, unless a further key follows the rest; mid-sequence rests are stored as note 0.
- Saturation:
  - Stimulus: hold key 7 for 300 ticks with DUR_W=8.
  - Response: entries {7,o,255}, then {7,o,45} after release.
- Full:
  - Stimulus: 70 alternating key changes.
  - Response: full=1 at count=64, state DONE; entry 63 is the last write; no further writes. clear then gives count=0, full=0.
- Reset mid-capture:
  - Stimulus: drop reset while in CAPTURE with count=5.
  - Response: all outputs go to their reset values immediately, without waiting for clk.
- Debounce (macro defined):
  - Stimulus: 2-cycle pulse on key 4 during key 1.
  - Response: no extra entry is written. Undefined: an entry {4,o,1} appears.
